// File: rtl/note_window_sequencer.sv
// Per-frame sweep of 4 note lanes through the window lookup; windows published atomically.
// Latency: request edge to done = 6 cycles (LOAD, 4x LOOKUP, PUBLISH); busy for those 6.
// Backpressure: one request queued while busy; further requests dropped and counted.
module note_window_sequencer #(
    parameter int DEPTH = 360,
    parameter int WIN   = 18
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_start,
    input  logic [9:0]               scroll_pos,
    input  logic [3:0]               lane_en,
    input  logic [WIN-1:0]           possible,
    output logic [1:0]               freq,
    output logic [9:0]               from,
    output logic [9:0]               to,
    output logic                     busy,
    output logic                     done,
    output logic [3:0][WIN-1:0]      windows,
    output logic                     windows_valid,
    output logic [7:0]               overrun_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, LOOKUP, PUBLISH} state_t;

    localparam logic [9:0] LAST = 10'(DEPTH - 1);

    state_t             state, state_nxt;
    logic               pending, pending_nxt;
    logic               overrun_inc;
    logic [3:0][WIN-1:0] shadow;
    logic [9:0]         pos_clip;
    logic [10:0]        end_raw;
    logic [9:0]         end_clip;

    // End position is formed at 11 bits so a head near 1023 cannot wrap.
    always_comb begin
        pos_clip = (scroll_pos > LAST) ? LAST : scroll_pos;
        end_raw  = {1'b0, pos_clip} + 11'(WIN - 1);
        end_clip = (end_raw > {1'b0, LAST}) ? LAST : end_raw[9:0];
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        overrun_inc = 1'b0;
        if (state != IDLE && frame_start) begin
            if (!pending) pending_nxt = 1'b1;
            else          overrun_inc = 1'b1;
        end
        case (state)
            IDLE: begin
                if (frame_start || pending) begin
                    state_nxt   = LOAD;
                    pending_nxt = 1'b0;
                end
            end
            LOAD:   state_nxt = LOOKUP;
            LOOKUP: if (freq == 2'd3) state_nxt = PUBLISH;
            PUBLISH: begin
                // A request arriving in this very cycle still chains straight into LOAD.
                if (pending_nxt) begin
                    state_nxt   = LOAD;
                    pending_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            pending       <= 1'b0;
            freq          <= 2'd0;
            from          <= 10'd0;
            to            <= 10'd0;
            done          <= 1'b0;
            windows       <= '0;
            windows_valid <= 1'b0;
            overrun_cnt   <= 8'd0;
            shadow        <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            done    <= 1'b0;
            if (overrun_inc && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
            case (state)
                LOAD: begin
                    from <= pos_clip;
                    to   <= end_clip;
                    freq <= 2'd0;
                end
                LOOKUP: begin
                    // freq doubles as the lane index; disabled lanes still spend their cycle.
                    shadow[freq] <= lane_en[freq] ? possible : '0;
                    if (freq != 2'd3) freq <= freq + 2'd1;
                end
                PUBLISH: begin
                    windows       <= shadow;
                    windows_valid <= 1'b1;
                    done          <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
